// File: rtl/alu_op_scheduler_pkg.sv
// rtl/alu_op_scheduler_pkg.sv - shared types and widths for the ALU operation scheduler
package alu_op_scheduler_pkg;

  localparam int OPND_W = 3;
  localparam int OP_W   = 3;
  localparam int RES_W  = 6;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_3bit.sv
// rtl/alu_3bit.sv - 3-bit ALU with 6-bit result, purely combinational
module alu_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [2:0] ctrl,
  output logic [5:0] leds
);

  logic [5:0] a_ext;
  logic [5:0] b_ext;

  assign a_ext = {3'b000, a};
  assign b_ext = {3'b000, b};

  // Operation select; subtraction and shift wrap modulo 64
  always_comb begin
    leds = 6'd0;
    case (ctrl)
      3'd0: leds = a_ext + b_ext;
      3'd1: leds = a_ext - b_ext;
      3'd2: leds = {3'b000, a & b};
      3'd3: leds = {3'b000, a | b};
      3'd4: leds = {3'b000, a ^ b};
      3'd5: leds = a_ext * b_ext;
      3'd6: leds = a_ext << b;
      default: leds = {3'b000, ~a};
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, one-hot or zero
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // A lone request always wins; on contention the pointer picks the winner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - two-requester ALU operation scheduler with result handshake
module alu_op_scheduler
  import alu_op_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              res_valid,
  output logic [RES_W-1:0]  res_data,
  output logic              res_id,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [OPND_W-1:0]   opa_q, opa_d;
  logic [OPND_W-1:0]   opb_q, opb_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                id_q, id_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;
  logic                res_id_q, res_id_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;
  logic [RES_W-1:0]    alu_res;
  logic [1:0]          arb_req;
  logic [1:0]          grant;

  // Requests are only visible to the arbiter while idle and out of reset
  assign arb_req = (state_q == ST_IDLE && !rst) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // The ALU sees only the latched operands, never the live requester inputs
  alu_3bit u_alu (
    .a    (opa_q),
    .b    (opb_q),
    .ctrl (op_q),
    .leds (alu_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant -> EXEC -> DONE -> (consumer accepts) -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant != 2'b00) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    busy       = (state_q != ST_IDLE);
    res_valid  = (state_q == ST_DONE);
  end

  // Datapath next values: latch on grant, capture in EXEC, count on result handshake
  always_comb begin
    ptr_d      = ptr_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    op_d       = op_q;
    id_d       = id_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    done_cnt_d = done_cnt_q;
    if (grant[1]) begin
      opa_d = req1_a;
      opb_d = req1_b;
      op_d  = req1_op;
      id_d  = 1'b1;
      ptr_d = 1'b0;
    end else if (grant[0]) begin
      opa_d = req0_a;
      opb_d = req0_b;
      op_d  = req0_op;
      id_d  = 1'b0;
      ptr_d = 1'b1;
    end
    if (state_q == ST_EXEC) begin
      res_data_d = alu_res;
      res_id_d   = id_q;
    end
    if (state_q == ST_DONE && res_ready) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      op_q       <= op_d;
      id_q       <= id_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign res_data = res_data_q;
  assign res_id   = res_id_q;
  assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - scoreboard bench for alu_op_scheduler
module tb_alu_op_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [5:0] res_data;
  logic       res_id;
  logic       res_ready;
  logic       busy;
  logic [7:0] done_cnt;

  always #5 clk = ~clk;

  alu_op_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_cnt = 0;
  logic prev_rv = 1'b0;

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int alu_ref(input int a, input int b, input int op);
    case (op)
      0: return a + b;
      1: return (a - b) & 63;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a * b;
      6: return (a << b) & 63;
      default: return 7 - a;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on request handshake, check latency and pop on result handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      model_cnt <= 0;
      prev_rv   <= 1'b0;
    end else begin
      if (req0_valid && req0_ready) begin
        e.id = 0; e.data = alu_ref(req0_a, req0_b, req0_op); e.cyc = cyc;
        sb.push_back(e);
      end
      if (req1_valid && req1_ready) begin
        e.id = 1; e.data = alu_ref(req1_a, req1_b, req1_op); e.cyc = cyc;
        sb.push_back(e);
      end
      if (res_valid && !prev_rv && sb.size() > 0) begin
        check_eq("latency", cyc, sb[0].cyc + 2);
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_result", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("res_data", res_data, e.data);
          check_eq("res_id", res_id, e.id);
          model_cnt <= (model_cnt + 1) % 256;
        end
      end
      prev_rv <= res_valid;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cyc();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic run_op(input logic id, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] op, output int waited);
    int n;
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
    waited = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!(id ? req1_ready : req0_ready)) check_eq("grant_timeout", id ? req1_ready : req0_ready, 1);
    next_cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 3'($urandom); req0_b = 3'($urandom); req0_op = 3'($urandom);
    req1_a = 3'($urandom); req1_b = 3'($urandom); req1_op = 3'($urandom);
    n = 0;
    @(negedge clk);
    while (!(res_valid && res_ready) && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!(res_valid && res_ready)) check_eq("result_timeout", res_valid && res_ready, 1);
    next_cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int grants;
    int last;
    int exp_id;
    logic g0, g1;

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 3'd1; req0_b = 3'd2; req0_op = 3'd0;
    req1_a = 3'd4; req1_b = 3'd5; req1_op = 3'd1;
    res_ready = 1'b1;

    // Reset held two cycles with both requesters valid
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_req0_ready", req0_ready, 0);
      check_eq("rst_req1_ready", req1_ready, 0);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_done_cnt", done_cnt, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_res_data", res_data, 0);
    end
    next_cyc();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset in EXEC discards the operation and restores the pointer
    req0_a = 3'd1; req0_b = 3'd1; req0_op = 3'd0; req0_valid = 1'b1;
    @(negedge clk);
    check_eq("mid_grant", req0_ready, 1);
    next_cyc();
    req0_valid = 1'b0;
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_res_valid", res_valid, 0);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_done_cnt", done_cnt, 0);
    next_cyc();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_eq("mid_ptr_req0", req0_ready, 1);
    check_eq("mid_ptr_req1", req1_ready, 0);
    next_cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) next_cyc();

    // Single request, then one of each opcode including boundary operands
    do_reset();
    run_op(1'b0, 3'd3, 3'd2, 3'd0, w);
    check_eq("single_wait", w, 0);
    @(negedge clk);
    check_eq("single_done_cnt", done_cnt, 1);
    check_eq("single_busy", busy, 0);
    next_cyc();
    run_op(1'b1, 3'd0, 3'd7, 3'd1, w);
    run_op(1'b0, 3'd7, 3'd7, 3'd5, w);
    run_op(1'b1, 3'd7, 3'd7, 3'd6, w);
    run_op(1'b0, 3'd5, 3'd1, 3'd6, w);
    for (int op = 0; op < 8; op++) begin
      run_op(1'($urandom), 3'($urandom), 3'($urandom), 3'(op), w);
    end
    @(negedge clk);
    check_eq("ops_done_cnt", done_cnt, model_cnt);

    // Contention: both valid continuously, grants must alternate every 3 cycles
    do_reset();
    res_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    exp_id = 0; last = -1; grants = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      if (g0 || g1) begin
        check_eq("cont_onehot", g0 && g1, 0);
        check_eq("cont_id", g1, exp_id);
        if (last >= 0) check_eq("cont_gap", cyc - last, 3);
        last = cyc;
        exp_id = exp_id ^ 1;
        grants++;
      end
      next_cyc();
      if (g0) begin req0_a = 3'($urandom); req0_b = 3'($urandom); req0_op = 3'($urandom); end
      if (g1) begin req1_a = 3'($urandom); req1_b = 3'($urandom); req1_op = 3'($urandom); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) next_cyc();
    check_eq("cont_grants", grants, 4);

    // Backpressure: result held stable, requests ignored, release returns to IDLE
    res_ready = 1'b0;
    req1_a = 3'd5; req1_b = 3'd6; req1_op = 3'd5; req1_valid = 1'b1;
    @(negedge clk);
    check_eq("bp_grant", req1_ready, 1);
    next_cyc();
    req1_valid = 1'b0;
    req1_a = 3'd0; req1_b = 3'd0; req1_op = 3'd7;
    w = 0;
    @(negedge clk);
    while (!res_valid && w < 5) begin
      w++;
      @(negedge clk);
    end
    check_eq("bp_res_valid_up", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      check_eq("bp_res_valid", res_valid, 1);
      check_eq("bp_res_data", res_data, 30);
      check_eq("bp_res_id", res_id, 1);
      check_eq("bp_req0_ready", req0_ready, 0);
      check_eq("bp_req1_ready", req1_ready, 0);
      check_eq("bp_busy", busy, 1);
    end
    next_cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    next_cyc();
    @(negedge clk);
    check_eq("bp_release_busy", busy, 0);
    check_eq("bp_release_valid", res_valid, 0);
    w = model_cnt;
    repeat (3) next_cyc();
    @(negedge clk);
    check_eq("idle_res_ready_cnt", done_cnt, w);

    // Counter wrap after 256 completions
    do_reset();
    res_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      run_op(1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), w);
      if (k == 254) begin
        @(negedge clk);
        check_eq("wrap_255", done_cnt, 255);
        next_cyc();
      end
    end
    @(negedge clk);
    check_eq("wrap_0", done_cnt, 0);
    check_eq("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous reset, active-high, sampled on clk rising edge.
REQ-003 SHALL have ports: req0_valid, req1_valid  in  1 each  requester has an operation pending.
REQ-004 SHALL have ports: req0_a, req0_b, req1_a, req1_b  in  3 each  ALU operands A/B per requester.
REQ-005 SHALL have ports: req0_op, req1_op  in  3 each  ALU ctrl code per requester, passed unmodified.
REQ-006 SHALL have ports: req0_ready, req1_ready  out  1 each  request accepted this cycle (valid&&ready = handshake).
REQ-007 SHALL have ports: res_valid  out  1; res_data  out  6  ALU Leds result; res_id  out  1  requester that issued it.
REQ-008 SHALL have ports: res_ready  in  1  consumer accepts result.
REQ-009 SHALL have ports: busy  out  1  high when not in IDLE; done_cnt  out  8  completed-result count.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, DONE; reset state IDLE.
REQ-011 IDLE: if no reqN_valid, SHALL stay IDLE with both readies low.
REQ-012 IDLE: if exactly one reqN_valid, SHALL grant it regardless of priority pointer.
REQ-013 IDLE: if both valid, SHALL grant requester indicated by round-robin pointer.
REQ-014 On grant, SHALL drive reqN_ready high combinationally for the granted requester only, in that IDLE cycle; other ready stays low.
REQ-015 On grant, SHALL latch a, b, op, id into operand registers and go to EXEC next cycle.
REQ-016 Pointer SHALL update on each grant to the non-granted requester; reset value selects requester 0.
REQ-017 EXEC: SHALL drive ALU A/B/ctrl from operand registers only, capture the 6-bit ALU output into res_data, id into res_id, go to DONE.
REQ-018 DONE: SHALL hold res_valid=1 and res_data/res_id stable until res_ready=1.
REQ-019 DONE with res_ready=1: SHALL complete handshake, increment done_cnt, return to IDLE next cycle.
REQ-020 done_cnt SHALL wrap 255 -> 0 without flag.
REQ-021 Latency: grant in cycle N -> res_valid first high in cycle N+2; minimum issue interval 3 cycles.
REQ-022 Requests presented while busy SHALL be ignored (readies low); requester must hold valid and operands stable until ready.
REQ-023 res_ready asserted while res_valid=0 SHALL have no effect.
REQ-024 Operand/op changes on requester inputs after grant SHALL not affect the in-flight result.
REQ-025 busy SHALL be 1 in EXEC and DONE, 0 in IDLE.

Reset
REQ-026 On rst=1: state IDLE, res_valid=0, res_data=0, res_id=0, done_cnt=0, pointer=0, operand registers=0, readies=0.
REQ-027 rst=1 mid-EXEC or mid-DONE SHALL discard the in-flight operation; no result delivered, done_cnt not incremented.
REQ-028 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-029 Shared package SHALL hold: FSM state typedef (IDLE/EXEC/DONE), operand width 3, op width 3, result width 6, counter width 8.
REQ-030 SHALL instantiate the existing 3-bit ALU module unchanged as the sole datapath.
REQ-031 SHALL place the 2-way round-robin grant logic in one sub-module rr_arb2 (inputs req[1:0], ptr; output grant[1:0], one-hot or zero).
REQ-032 Top-level integration SHALL tie unused outputs to 0.

Verification
REQ-033 Reset: assert rst 2 cycles with both valids high -> readies 0, res_valid 0, done_cnt 0, busy 0.
REQ-034 Single request: req0 a=3,b=2,op=0 at cycle N -> req0_ready=1 at N, res_valid=1 at N+2, res_data = ALU(A=3,B=2,ctrl=0), res_id=0, done_cnt=1 after res_ready.
REQ-035 Contention: both valid continuously, res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; issue every 3 cycles.
REQ-036 Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid and res_data stable, readies 0, busy 1; release -> IDLE next cycle.
REQ-037 Reset mid-operation: rst in EXEC -> next cycle res_valid 0, done_cnt unchanged, pointer 0.
REQ-038 Counter wrap: complete 256 operations -> done_cnt returns to 0.
